// File: rtl/read_scheduler.sv
// Two-master read arbiter/scheduler: round-robin AR grant, slave decode from the
// latched address page, AR wait timeout, and R beat counting with length checking.
module read_scheduler #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid_m0_i,
  input  logic        arvalid_m1_i,
  input  logic [31:0] araddr_m0_i,
  input  logic [31:0] araddr_m1_i,
  input  logic [3:0]  arlen_m0_i,
  input  logic [3:0]  arlen_m1_i,
  input  logic        arready_s_i,
  input  logic        rvalid_s_i,
  input  logic        rlast_s_i,
  input  logic        rready_m_i,
  output logic [1:0]  grant_o,
  output logic [1:0]  sel_o,
  output logic        arvalid_s_o,
  output logic        arready_m0_o,
  output logic        arready_m1_o,
  output logic        busy_o,
  output logic        timeout_o,
  output logic        len_err_o
);

  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ABORT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [15:0]   page_q, page_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          last_q, last_d;      // 1 = M1 was granted last
  logic          rst_done_q;
  logic          win_m1;
  logic          hs;

  // Only the page bits select the slave; the low address bits pass straight to the slave side.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{araddr_m0_i[15:0], araddr_m1_i[15:0]};

  assign win_m1 = arvalid_m1_i & (~arvalid_m0_i | ~last_q);
  assign hs     = rvalid_s_i & rready_m_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      page_q     <= 16'h0000;
      len_q      <= 4'h0;
      cnt_q      <= 4'h0;
      wait_q     <= '0;
      last_q     <= 1'b1;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      page_q     <= page_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      last_q     <= last_d;
      rst_done_q <= 1'b1;
    end
  end

  // rst_done_q holds off arbitration for the first edge after reset release.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    page_d  = page_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (rst_done_q && (arvalid_m0_i || arvalid_m1_i)) begin
          state_d = ADDR;
          grant_d = win_m1 ? 2'b10 : 2'b01;
          page_d  = win_m1 ? araddr_m1_i[31:16] : araddr_m0_i[31:16];
          len_d   = win_m1 ? arlen_m1_i : arlen_m0_i;
          wait_d  = '0;
        end
      end
      ADDR: begin
        if (arready_s_i) begin
          state_d = DATA;
          cnt_d   = 4'h0;
          last_d  = grant_q[1];
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          state_d = ABORT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DATA: begin
        if (hs) begin
          if (rlast_s_i) state_d = IDLE;
          else if (cnt_q != len_q) cnt_d = cnt_q + 1'b1;
        end
      end
      ABORT: begin
        state_d = IDLE;
        last_d  = grant_q[1];
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_o      = 2'b00;
    arvalid_s_o  = 1'b0;
    arready_m0_o = 1'b0;
    arready_m1_o = 1'b0;
    busy_o       = 1'b0;
    timeout_o    = 1'b0;
    len_err_o    = 1'b0;
    case (page_q)
      16'h0000: sel_o = 2'd0;
      16'h0001: sel_o = 2'd1;
      16'h0002: sel_o = 2'd2;
      default:  sel_o = 2'd3;
    endcase
    case (state_q)
      ADDR: begin
        grant_o      = grant_q;
        busy_o       = 1'b1;
        arvalid_s_o  = 1'b1;
        arready_m0_o = grant_q[0] & arready_s_i;
        arready_m1_o = grant_q[1] & arready_s_i;
      end
      DATA: begin
        grant_o   = grant_q;
        busy_o    = 1'b1;
        len_err_o = hs & (rlast_s_i ? (cnt_q != len_q) : (cnt_q == len_q));
      end
      ABORT:   timeout_o = 1'b1;
      default: ;
    endcase
  end

endmodule
